// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-memory bridge.
// The optional REQ timeout is enabled with the MEM_BRIDGE_TIMEOUT_EN macro.
package mem_bridge_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 15;
  localparam int unsigned DEF_DATA_W         = 32;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Bundles the CPU-side request/response and memory-side handshake of mem_bridge.
// slave is the bridge's view; master is the view of the surrounding CPU/memory.
interface mem_bridge_if import mem_bridge_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              err;

  logic              mem_valid;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    output cpu_rdata, cpu_ready, err, mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
    input  cpu_rdata, cpu_ready, err, mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bridge_timer.sv
// REQ-phase watchdog: cleared by load, counts enabled cycles, and flags the
// cycle whose increment would reach LIMIT. Used only with MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge_timer import mem_bridge_pkg::*; #(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    W    = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is flagged while the counter sits one below LIMIT so that the
  // FSM leaves REQ on the same edge that the count reaches LIMIT.
  always_comb begin
    expired = enable && (count == LAST);
  end

endmodule

// File: rtl/mem_bridge.sv
// Multicycle CPU to single-port memory bridge with alignment check.
// Optional REQ timeout is compiled in with MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge import mem_bridge_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DATA_W         = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  mem_bridge_if.slave  bus
);

  state_t state;
  state_t state_next;

  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;

  logic accept;
  logic timed_out;

  always_comb begin
    accept = (state == ST_IDLE) && bus.cpu_req && is_aligned(bus.cpu_addr[1:0]);
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic timer_enable;
  logic timer_expired;

  always_comb begin
    timer_enable = (state == ST_REQ) && !bus.mem_ready;
  end

  mem_bridge_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    timed_out = timer_expired;
  end
`else
  always_comb begin
    timed_out = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_next = is_aligned(bus.cpu_addr[1:0]) ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        // A completion in the same cycle as the timeout limit takes priority.
        if (bus.mem_ready) begin
          state_next = ST_DONE;
        end else if (timed_out) begin
          state_next = ST_ERR;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        req_we    <= bus.cpu_we;
        req_addr  <= bus.cpu_addr;
        req_wdata <= bus.cpu_wdata;
      end
      if ((state == ST_REQ) && bus.mem_ready && !req_we) begin
        rdata <= bus.mem_rdata;
      end
    end
  end

  // Handshake outputs decode the registered state directly, so an
  // asynchronous reset removes mem_valid without waiting for a clock edge.
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.err       = 1'b0;
    case (state)
      ST_REQ:  bus.mem_valid = 1'b1;
      ST_DONE: bus.cpu_ready = 1'b1;
      ST_ERR: begin
        bus.cpu_ready = 1'b1;
        bus.err       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mem_we    = req_we;
    bus.mem_addr  = req_addr;
    bus.mem_wdata = req_wdata;
    bus.cpu_rdata = rdata;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles the bridge SHALL wait for mem_ready in REQ (used only under MEM_BRIDGE_TIMEOUT_EN).
REQ-002 Parameter DATA_W, default 32: the data and address width in bits.
REQ-003 Reset and clock SHALL be: reset, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 cpu_req  input  1  transaction request from the multicycle controller/datapath.
REQ-007 cpu_we  input  1  1 = write, 0 = read.
REQ-008 cpu_addr  input  DATA_W  byte address (selected by iord upstream).
REQ-009 cpu_wdata  input  DATA_W  store data.
REQ-010 cpu_rdata  output  DATA_W  last completed read data, registered.
REQ-011 cpu_ready  output  1  one-cycle completion pulse, used as the controller's advance/stall.
REQ-012 err  output  1  one-cycle error flag, coincident with cpu_ready.
REQ-013 mem_valid  output  1  request to the memory.
REQ-014 mem_we, mem_addr, mem_wdata  output  1/DATA_W/DATA_W  registered copies of the accepted request.
REQ-015 mem_ready  input  1  memory completion; mem_rdata is valid in the same cycle.
REQ-016 mem_rdata  input  DATA_W  memory read data.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, DONE and ERR.
REQ-018 IDLE: if cpu_req=1 and cpu_addr[1:0]==0, the bridge SHALL latch cpu_we/addr/wdata and move to REQ.
REQ-019 IDLE: if cpu_req=1 and cpu_addr[1:0]!=0, the bridge SHALL move to ERR without asserting mem_valid.
REQ-020 REQ: mem_valid SHALL be 1, and mem_we/addr/wdata SHALL be held stable until mem_ready=1.
REQ-021 REQ with mem_ready=1: the bridge SHALL capture mem_rdata into cpu_rdata if it is a read and move to DONE.
REQ-022 REQ with mem_ready=1: for a write, cpu_rdata SHALL be unchanged.
REQ-023 DONE: cpu_ready=1 and err=0 for exactly one cycle, then the bridge SHALL move to IDLE.
REQ-024 ERR: cpu_ready=1 and err=1 for exactly one cycle, cpu_rdata SHALL be unchanged, then the bridge SHALL move to IDLE.
REQ-025 Latency: a request sampled in IDLE at cycle N gives mem_valid at N+1; mem_ready at N+k (k>=1) gives cpu_ready at N+k+1; the minimum is 2 cycles.
REQ-026 cpu_req high in IDLE (including the cycle after DONE/ERR) SHALL start a new transaction; the requester deasserts cpu_req in the cycle after cpu_ready.
REQ-027 Changes on cpu_req/cpu_addr/cpu_we/cpu_wdata outside IDLE SHALL be ignored.
REQ-028 mem_ready while not in REQ SHALL be ignored.
REQ-029 mem_valid SHALL be 0 in IDLE, DONE and ERR.

Reset
REQ-030 On reset: state=IDLE, mem_valid=0, cpu_ready=0, err=0, and cpu_rdata/mem_addr/mem_wdata/mem_we/timeout counter =0.
REQ-031 Reset during REQ SHALL drop mem_valid immediately (asynchronously) and SHALL produce no cpu_ready.

Configuration
REQ-032 Macro MEM_BRIDGE_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to REQ and increment each REQ cycle with mem_ready=0.
REQ-033 MEM_BRIDGE_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES, the bridge SHALL drop mem_valid next cycle and go to ERR.
REQ-034 MEM_BRIDGE_TIMEOUT_EN defined: mem_ready in the same cycle as the limit SHALL win (DONE).
REQ-035 MEM_BRIDGE_TIMEOUT_EN undefined: REQ SHALL wait indefinitely, err SHALL come only from misalignment, and no counter logic SHALL exist.

Structure
REQ-036 Package mem_bridge_pkg SHALL hold the state enum typedef (2-bit), the default TIMEOUT_CYCLES and DATA_W constants, and the alignment-mask constant.
REQ-037 Sub-module mem_bridge_timer (load/enable/expired) SHALL be instantiated only under MEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-038 Read 0x0000_0010, mem_ready one cycle after mem_valid with mem_rdata=0xDEADBEEF -> cpu_ready 3 cycles after request sample, cpu_rdata=0xDEADBEEF, err=0.
REQ-039 Write addr 0x20 data 0x1234_5678, mem_ready delayed 4 cycles -> mem_addr/wdata/we stable for all 5 REQ cycles, one cpu_ready pulse, cpu_rdata unchanged.
REQ-040 Read addr 0x0000_0013 -> mem_valid never asserted, cpu_ready=err=1 for one cycle at N+1.
REQ-041 With MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=15, mem_ready held 0 -> mem_valid drops after 15 REQ cycles, err pulse.
REQ-042 With MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=15, mem_ready on the 15th cycle -> normal DONE, err=0.
REQ-043 reset asserted 2 cycles into REQ -> mem_valid=0 immediately, no cpu_ready, and the next read after release completes normally.
REQ-044 cpu_req held high across DONE -> a second transaction starts, and a mem_ready pulse in IDLE is ignored.
